// File: rtl/jogo_memoria_param_if.sv
// Board-side bundle of the memory game: start key, buttons, LEDs,
// result flags and the raw debug buses fed to the 7-segment decoders.
interface jogo_memoria_param_if #(
    parameter int NBOTOES = 4,
    parameter int AW      = 4
);
    logic               iniciar;
    logic [NBOTOES-1:0] botoes;
    logic [NBOTOES-1:0] leds;
    logic               pronto;
    logic               ganhou;
    logic               perdeu;
    logic [3:0]         db_estado;
    logic [AW-1:0]      db_rodada;
    logic [AW-1:0]      db_endereco;
    logic               db_timeout;

    modport master (
        output iniciar,
        output botoes,
        input  leds,
        input  pronto,
        input  ganhou,
        input  perdeu,
        input  db_estado,
        input  db_rodada,
        input  db_endereco,
        input  db_timeout
    );

    modport slave (
        input  iniciar,
        input  botoes,
        output leds,
        output pronto,
        output ganhou,
        output perdeu,
        output db_estado,
        output db_rodada,
        output db_endereco,
        output db_timeout
    );
endinterface

// File: rtl/jogo_memoria_param.sv
// Simon-style memory game: the player replays a growing one-hot sequence.
// Define JOGO_TIMEOUT_EN to build the per-press response timeout.
module jogo_memoria_param #(
    parameter int NBOTOES     = 4,
    parameter int PROF        = 16,
    parameter int TIMEOUT     = 5000,
    parameter int EXIBE       = 1000,
    parameter int INICIAL_IDX = 0
) (
    input logic                 clock,
    input logic                 reset,
    jogo_memoria_param_if.slave bus
);
    localparam int AW = $clog2(PROF);
    localparam int EW = (EXIBE > 1) ? $clog2(EXIBE) : 1;
    localparam logic [NBOTOES-1:0] INICIAL = NBOTOES'(1) << INICIAL_IDX;

    typedef enum logic [3:0] {
        ST_INICIAL     = 4'd0,
        ST_PREPARA     = 4'd1,
        ST_EXIBE       = 4'd2,
        ST_ESPERA      = 4'd3,
        ST_COMPARA     = 4'd4,
        ST_PROX_END    = 4'd5,
        ST_ESPERA_NOVA = 4'd6,
        ST_GRAVA       = 4'd7,
        ST_PROX_RODADA = 4'd8,
        ST_ACERTOU     = 4'd10,
        ST_ERROU       = 4'd11
    } estado_t;

    estado_t            estado;
    estado_t            proximo;
    logic [NBOTOES-1:0] mem [PROF];
    logic [NBOTOES-1:0] jogada;
    logic [AW-1:0]      rodada;
    logic [AW-1:0]      endereco;
    logic [EW-1:0]      cnt_exibe;
    logic               qualquer;
    logic               qualquer_d;
    logic               evento;
    logic               botoes_ok;
    logic               jogada_ok;
    logic               exibe_fim;
    logic               estouro;
    logic               esperando;
    logic [NBOTOES-1:0] leds;
    logic               pronto;
    logic               ganhou;
    logic               perdeu;
    logic               timeout_q;

    function automatic logic one_hot(input logic [NBOTOES-1:0] v);
        return (v != '0) && ((v & (v - NBOTOES'(1))) == '0);
    endfunction

    // Only the rising edge of "any button" counts, so holding never repeats.
    assign qualquer  = |bus.botoes;
    assign evento    = qualquer & ~qualquer_d;
    assign botoes_ok = one_hot(bus.botoes);
    assign jogada_ok = one_hot(jogada);
    assign exibe_fim = (cnt_exibe == EW'(EXIBE - 1));
    assign esperando = (estado == ST_ESPERA) || (estado == ST_ESPERA_NOVA);

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_timeout;

    // A press in the last allowed cycle still wins over the timeout.
    assign estouro = (cnt_timeout == TW'(TIMEOUT - 1)) && !evento;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_timeout <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (esperando) begin
                cnt_timeout <= cnt_timeout + TW'(1);
            end else begin
                cnt_timeout <= '0;
            end
            if (estado == ST_PREPARA) begin
                timeout_q <= 1'b0;
            end else if (esperando && estouro) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign estouro   = 1'b0;
    assign timeout_q = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= ST_INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qualquer_d <= 1'b0;
            jogada     <= '0;
            rodada     <= '0;
            endereco   <= '0;
            cnt_exibe  <= '0;
        end else begin
            qualquer_d <= qualquer;
            if (evento) begin
                jogada <= bus.botoes;
            end
            case (estado)
                ST_PREPARA: begin
                    rodada    <= '0;
                    endereco  <= '0;
                    cnt_exibe <= '0;
                end
                ST_EXIBE: begin
                    cnt_exibe <= cnt_exibe + EW'(1);
                end
                ST_PROX_END: begin
                    endereco <= endereco + AW'(1);
                end
                ST_PROX_RODADA: begin
                    rodada   <= rodada + AW'(1);
                    endereco <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequence storage is deliberately unreset; PREPARA seeds entry 0.
    always_ff @(posedge clock) begin
        if (estado == ST_PREPARA) begin
            mem[0] <= INICIAL;
        end else if (estado == ST_GRAVA) begin
            mem[rodada + AW'(1)] <= jogada;
        end
    end

    always_comb begin
        proximo = estado;
        leds    = '0;
        pronto  = 1'b0;
        ganhou  = 1'b0;
        perdeu  = 1'b0;
        unique case (estado)
            ST_INICIAL: begin
                if (bus.iniciar) proximo = ST_PREPARA;
            end
            ST_PREPARA: begin
                proximo = ST_EXIBE;
            end
            ST_EXIBE: begin
                leds = mem[0];
                if (exibe_fim) proximo = ST_ESPERA;
            end
            ST_ESPERA: begin
                leds = bus.botoes;
                if (evento) begin
                    proximo = ST_COMPARA;
                end else if (estouro) begin
                    proximo = ST_ERROU;
                end
            end
            ST_COMPARA: begin
                if (!jogada_ok || jogada != mem[endereco]) begin
                    proximo = ST_ERROU;
                end else if (endereco == rodada &&
                             rodada == AW'(PROF - 1)) begin
                    proximo = ST_ACERTOU;
                end else if (endereco == rodada) begin
                    proximo = ST_ESPERA_NOVA;
                end else begin
                    proximo = ST_PROX_END;
                end
            end
            ST_PROX_END: begin
                proximo = ST_ESPERA;
            end
            ST_ESPERA_NOVA: begin
                leds = bus.botoes;
                if (evento) begin
                    proximo = botoes_ok ? ST_GRAVA : ST_ERROU;
                end else if (estouro) begin
                    proximo = ST_ERROU;
                end
            end
            ST_GRAVA: begin
                proximo = ST_PROX_RODADA;
            end
            ST_PROX_RODADA: begin
                proximo = ST_ESPERA;
            end
            ST_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
                if (bus.iniciar) proximo = ST_PREPARA;
            end
            ST_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
                if (bus.iniciar) proximo = ST_PREPARA;
            end
            default: begin
                proximo = ST_INICIAL;
            end
        endcase
    end

    assign bus.leds        = leds;
    assign bus.pronto      = pronto;
    assign bus.ganhou      = ganhou;
    assign bus.perdeu      = perdeu;
    assign bus.db_estado   = estado;
    assign bus.db_rodada   = rodada;
    assign bus.db_endereco = endereco;
    assign bus.db_timeout  = timeout_q;
endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for the memory game: win, wrong move, timeout,
// invalid/held presses and mid-game reset.
module tb_jogo_memoria_param;
    localparam int NBOTOES = 4;
    localparam int PROF    = 4;
    localparam int AW      = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    jogo_memoria_param_if #(.NBOTOES(NBOTOES), .AW(AW)) jogo ();

    jogo_memoria_param #(
        .NBOTOES(NBOTOES),
        .PROF(PROF),
        .TIMEOUT(20),
        .EXIBE(3),
        .INICIAL_IDX(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(jogo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input int s);
        int n = 0;
        while (int'(jogo.db_estado) != s && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("wait_state", int'(jogo.db_estado), s);
    endtask

    task automatic wait_play();
        int n = 0;
        while (jogo.db_estado != 4'd3 && jogo.db_estado != 4'd6 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("wait_play", int'(jogo.db_estado), 3);
    endtask

    task automatic press(input logic [3:0] v);
        wait_play();
        jogo.botoes = v;
        tick(1);
        jogo.botoes = '0;
        tick(1);
    endtask

    task automatic start();
        jogo.iniciar = 1'b1;
        tick(1);
        jogo.iniciar = 1'b0;
    endtask

    task automatic check_idle(input string pre);
        check({pre, "_estado"}, int'(jogo.db_estado), 0);
        check({pre, "_leds"}, int'(jogo.leds), 0);
        check({pre, "_pronto"}, int'(jogo.pronto), 0);
        check({pre, "_ganhou"}, int'(jogo.ganhou), 0);
        check({pre, "_perdeu"}, int'(jogo.perdeu), 0);
        check({pre, "_rodada"}, int'(jogo.db_rodada), 0);
        check({pre, "_endereco"}, int'(jogo.db_endereco), 0);
        check({pre, "_timeout"}, int'(jogo.db_timeout), 0);
    endtask

    initial begin
        jogo.iniciar = 1'b0;
        jogo.botoes  = '0;
        tick(2);
        check_idle("rst");
        reset = 1'b0;
        tick(1);
        check("rst_hold_estado", int'(jogo.db_estado), 0);

        // Full win over four rounds
        start();
        check("start_prepara", int'(jogo.db_estado), 1);
        press(4'b0001);
        check("r0_nova", int'(jogo.db_estado), 6);
        press(4'b0010);
        press(4'b0001);
        press(4'b0010);
        check("r1_nova", int'(jogo.db_estado), 6);
        check("r1_rodada", int'(jogo.db_rodada), 1);
        press(4'b0100);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        check("r3_prox_end", int'(jogo.db_estado), 5);
        check("r3_endereco", int'(jogo.db_endereco), 2);
        press(4'b1000);
        check("win_estado", int'(jogo.db_estado), 10);
        check("win_ganhou", int'(jogo.ganhou), 1);
        check("win_pronto", int'(jogo.pronto), 1);
        check("win_perdeu", int'(jogo.perdeu), 0);
        check("win_rodada", int'(jogo.db_rodada), 3);
        tick(5);
        check("win_hold", int'(jogo.db_estado), 10);

        // Wrong move in round 1
        start();
        check("restart_prepara", int'(jogo.db_estado), 1);
        check("restart_ganhou", int'(jogo.ganhou), 0);
        press(4'b0001);
        press(4'b0010);
        press(4'b0001);
        press(4'b0100);
        check("wrong_estado", int'(jogo.db_estado), 11);
        check("wrong_perdeu", int'(jogo.perdeu), 1);
        check("wrong_pronto", int'(jogo.pronto), 1);
        check("wrong_ganhou", int'(jogo.ganhou), 0);
        check("wrong_timeout", int'(jogo.db_timeout), 0);

        // Two buttons at once
        start();
        press(4'b0011);
        check("inval_estado", int'(jogo.db_estado), 11);
        check("inval_perdeu", int'(jogo.perdeu), 1);

`ifdef JOGO_TIMEOUT_EN
        start();
        wait_state(3);
        tick(19);
        check("to_still_wait", int'(jogo.db_estado), 3);
        tick(1);
        check("to_estado", int'(jogo.db_estado), 11);
        check("to_perdeu", int'(jogo.perdeu), 1);
        check("to_flag", int'(jogo.db_timeout), 1);

        start();
        tick(1);
        check("to_clear", int'(jogo.db_timeout), 0);
        wait_state(3);
        tick(19);
        jogo.botoes = 4'b0001;
        tick(1);
        check("late_press_compara", int'(jogo.db_estado), 4);
        jogo.botoes = '0;
        tick(1);
        check("late_press_nova", int'(jogo.db_estado), 6);
        check("late_press_perdeu", int'(jogo.perdeu), 0);
        jogo.iniciar = 1'b1;
        tick(1);
        jogo.iniciar = 1'b0;
        check("ign_iniciar", int'(jogo.db_estado), 6);
`else
        start();
        wait_state(3);
        tick(200);
        check("noto_estado", int'(jogo.db_estado), 3);
        check("noto_perdeu", int'(jogo.perdeu), 0);
        check("noto_flag", int'(jogo.db_timeout), 0);
        jogo.iniciar = 1'b1;
        tick(1);
        jogo.iniciar = 1'b0;
        check("ign_iniciar", int'(jogo.db_estado), 3);
`endif

        reset = 1'b1;
        tick(1);
        check("abort_estado", int'(jogo.db_estado), 0);
        reset = 1'b0;
        tick(1);

        // Held button across GRAVA must not replay
        start();
        press(4'b0001);
        jogo.botoes = 4'b0010;
        tick(6);
        check("hold_estado", int'(jogo.db_estado), 3);
        check("hold_leds", int'(jogo.leds), 2);
        check("hold_rodada", int'(jogo.db_rodada), 1);
        check("hold_endereco", int'(jogo.db_endereco), 0);
        jogo.botoes = '0;
        tick(1);
        press(4'b0001);
        press(4'b0010);
        check("hold_stored", int'(jogo.db_estado), 6);
        press(4'b0100);
        press(4'b0001);
        check("r2_prox_end", int'(jogo.db_estado), 5);
        check("r2_rodada", int'(jogo.db_rodada), 2);

        // Reset in the middle of round 2
        reset = 1'b1;
        tick(1);
        check_idle("mid");
        reset = 1'b0;
        tick(1);
        start();
        check("re_prepara", int'(jogo.db_estado), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("re_exibe", int'(jogo.db_estado), 2);
            check("re_leds", int'(jogo.leds), 1);
        end
        tick(1);
        check("re_espera", int'(jogo.db_estado), 3);
        check("re_leds_off", int'(jogo.leds), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jogo_memoria_param.md
# jogo_memoria_param

Parametrised, single-module memory-sequence game (Simon style) for the lab board: `NBOTOES` one-hot buttons/LEDs, a sequence memory of `PROF` moves that the player builds up round by round, a configurable response timeout and an initial-move display phase. The block is driven directly by the board buttons and `iniciar` key. It drives the LEDs and the result flags, and exports raw debug buses that the board top feeds into `hexa7seg` decoders.

## Interface
- `NBOTOES`, 4: number of buttons/LEDs (≥2); plays are one-hot of this width.
- `PROF`, 16: sequence depth = rounds to win (power of 2, ≥2); `AW = $clog2(PROF)`.
- `TIMEOUT`, 5000: clock cycles allowed per press while waiting.
- `EXIBE`, 1000: clock cycles the initial move is shown on `leds`.
- `INICIAL_IDX`, 0: index of the bit set in the initial move, `mem[0]`.

- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `iniciar`  in  1  start/restart request.
- `botoes`  in  NBOTOES  raw button levels, already synchronised.
- `leds`  out  NBOTOES  move display / button echo.
- `pronto`  out  1  game finished.
- `ganhou`  out  1  game won.
- `perdeu`  out  1  game lost.
- `db_estado`  out  4  FSM state code.
- `db_rodada`  out  AW  current round.
- `db_endereco`  out  AW  current replay address.
- `db_timeout`  out  1  loss was caused by timeout.

## Operation
- Memory: `PROF` × `NBOTOES` registers, no reset. `mem[0]` is written in PREPARA; `mem[r+1]` is written in GRAVA.
- Press detection: `qualquer = |botoes`, registered as `qualquer_d`. A press event is `qualquer & ~qualquer_d`. On that event `jogada <= botoes`.
  - Holding a button never produces a second event.
  - A press with more than one bit set is invalid.
- FSM states (code):
  - INICIAL(0): outputs 0. `iniciar` → PREPARA.
  - PREPARA(1): zero rodada, endereco and counters; `mem[0] <=` one-hot(`INICIAL_IDX`). → EXIBE.
  - EXIBE(2): `leds = mem[0]` for `EXIBE` cycles. → ESPERA.
  - ESPERA(3): wait for a press. Press → COMPARA. Timeout with no press → ERROU and set `db_timeout`.
  - COMPARA(4), evaluated in this order:
    - invalid press or `jogada != mem[endereco]` → ERROU;
    - else `endereco == rodada` and `rodada == PROF-1` → ACERTOU;
    - else `endereco == rodada` → ESPERA_NOVA;
    - else → PROX_END.
  - PROX_END(5): `endereco++`, clear timeout counter. → ESPERA.
  - ESPERA_NOVA(6): wait for the new move. A valid press → GRAVA. Invalid press or timeout → ERROU (timeout also sets `db_timeout`).
  - GRAVA(7): `mem[rodada+1] <= jogada`. → PROX_RODADA.
  - PROX_RODADA(8): `rodada++`, `endereco <= 0`, clear timeout counter. → ESPERA.
  - ACERTOU(10): `pronto = ganhou = 1`. `iniciar` → PREPARA.
  - ERROU(11): `pronto = perdeu = 1`. `iniciar` → PREPARA.
- `leds`: `mem[0]` in EXIBE; equal to `botoes` in ESPERA and ESPERA_NOVA; 0 elsewhere.
- `iniciar` is ignored outside INICIAL, ACERTOU and ERROU.
- `db_timeout` clears in PREPARA.
- Counters wrap only through explicit clears; `rodada` never exceeds `PROF-1`.

## Timing
- Reset: state INICIAL. All outputs 0, counters 0, `qualquer_d` = 0.
- Reset mid-game aborts immediately. The next cycle shows INICIAL.
- `iniciar` high at edge t → PREPARA at t+1 → EXIBE from t+2 for exactly `EXIBE` cycles.
- Press event sampled at edge t (`jogada` registered) → COMPARA at t+1 → next state at t+2.
- Timeout counter clears on entry to ESPERA or ESPERA_NOVA. It fires when the count reaches `TIMEOUT-1` with no press event that cycle.
- A press and a timeout in the same cycle: the press wins.
- Result flags are registered-state decodes and hold until `iniciar` or `reset`.

## Configuration
- `JOGO_TIMEOUT_EN` defined: the timeout counter and `db_timeout` are active as above.
- Not defined: no timeout counter is built. ESPERA and ESPERA_NOVA wait forever, and `db_timeout` is tied to 0.

## Test plan
Bench parameters for all scenarios: `NBOTOES=4`, `PROF=4`, `TIMEOUT=20`, `EXIBE=3`, `INICIAL_IDX=0`, macro defined.
- Win: `iniciar`, then press 0001 and new 0010; replay 0001,0010 and new 0100; replay 0001,0010,0100 and new 1000; replay all four → `ganhou=pronto=1`, `perdeu=0`, `db_rodada=3`, `db_estado=10`.
- Wrong move: in round 1, press 0001 then 0100 where 0010 is stored → `perdeu=1`, `db_timeout=0`, `db_estado=11`.
- Timeout: after EXIBE, idle 20 cycles in ESPERA → `perdeu=1`, `db_timeout=1`. A press on cycle 19 instead → no loss.
- Invalid press: `botoes=0011` in ESPERA → ERROU. A button held across GRAVA→ESPERA → no second event.
- Reset mid-round 2 → next cycle `db_estado=0`, all outputs 0. Then `iniciar` → EXIBE shows `leds=0001` for 3 cycles.
- Macro undefined: idle 200 cycles in ESPERA → state stays 3, `perdeu=0`.
